// File: rtl/dmem_responder.sv
// Data-memory responder: word storage behind a req/ready handshake with
// programmable wait states and misaligned/out-of-range error reporting.
module dmem_responder #(
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned LATENCY = 2
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata,
    output logic        o_ready,
    output logic        o_err,
    output logic        o_busy
);

    localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic        r_ready;
    logic        r_err;
    logic        r_busy;
    logic [31:0] r_mem [DEPTH];

    logic [31:0]     w_acc_addr;
    logic            w_acc_we;
    logic            w_acc_err;
    logic [IdxW-1:0] w_acc_idx;
    logic [IdxW-1:0] w_wr_idx;

    // With zero wait states the response is formed from the live request in IDLE.
    always_comb begin
        w_acc_addr = (r_state == StIdle) ? i_addr : r_addr;
        w_acc_we   = (r_state == StIdle) ? i_we : r_we;
        w_acc_err  = (w_acc_addr[1:0] != 2'b00) || (w_acc_addr[31:2] >= 30'(DEPTH));
        w_acc_idx  = w_acc_addr[IdxW+1:2];
        w_wr_idx   = r_addr[IdxW+1:2];
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= StIdle;
            r_cnt   <= 4'd0;
            r_we    <= 1'b0;
            r_addr  <= 32'h0;
            r_wdata <= 32'h0;
            r_rdata <= 32'h0;
            r_ready <= 1'b0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            r_err   <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (i_req) begin
                        r_addr  <= i_addr;
                        r_we    <= i_we;
                        r_wdata <= i_wdata;
                        r_busy  <= 1'b1;
                        if (LATENCY == 0) begin
                            r_state <= StResp;
                            r_ready <= 1'b1;
                            r_err   <= w_acc_err;
                            if (w_acc_err) begin
                                r_rdata <= 32'h0;
                            end else if (!w_acc_we) begin
                                r_rdata <= r_mem[w_acc_idx];
                            end
                        end else begin
                            r_cnt   <= 4'(LATENCY);
                            r_state <= StWait;
                        end
                    end
                end
                StWait: begin
                    if (!i_req) begin
                        // Requester withdrew mid-access: drop it silently.
                        r_state <= StIdle;
                        r_busy  <= 1'b0;
                        r_cnt   <= 4'd0;
                    end else if (r_cnt == 4'd1) begin
                        r_state <= StResp;
                        r_cnt   <= 4'd0;
                        r_ready <= 1'b1;
                        r_err   <= w_acc_err;
                        if (w_acc_err) begin
                            r_rdata <= 32'h0;
                        end else if (!w_acc_we) begin
                            r_rdata <= r_mem[w_acc_idx];
                        end
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                StResp: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Store commits on the edge leaving RESP; a reset on that edge cancels it.
    always_ff @(posedge i_clock) begin
        if (!i_reset && (r_state == StResp) && r_we && !r_err) begin
            r_mem[w_wr_idx] <= r_wdata;
        end
    end

    assign o_rdata = r_rdata;
    assign o_ready = r_ready;
    assign o_err   = r_err;
    assign o_busy  = r_busy;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with two wait states,
// one with zero wait states, expected values written out by hand.
module tb_dmem_responder;

    logic        clk;
    logic        reset;
    logic        req,  we;
    logic [31:0] addr, wdata, rdata;
    logic        ready, err, busy;
    logic        req0, we0;
    logic [31:0] addr0, wdata0, rdata0;
    logic        ready0, err0, busy0;

    int n_checks = 0;
    int n_fail   = 0;

    dmem_responder #(.DEPTH(256), .LATENCY(2)) u_dut (
        .i_clock (clk),
        .i_reset (reset),
        .i_req   (req),
        .i_we    (we),
        .i_addr  (addr),
        .i_wdata (wdata),
        .o_rdata (rdata),
        .o_ready (ready),
        .o_err   (err),
        .o_busy  (busy)
    );

    dmem_responder #(.DEPTH(16), .LATENCY(0)) u_dut0 (
        .i_clock (clk),
        .i_reset (reset),
        .i_req   (req0),
        .i_we    (we0),
        .i_addr  (addr0),
        .i_wdata (wdata0),
        .o_rdata (rdata0),
        .o_ready (ready0),
        .o_err   (err0),
        .o_busy  (busy0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one access on the two-wait-state instance and check its response.
    task automatic access(input string tag, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic [31:0] exp_rdata,
                          input logic exp_err, input int exp_lat, input logic hold);
        int n;
        req   = 1'b1;
        we    = w;
        addr  = a;
        wdata = d;
        n     = 0;
        while (n < 20) begin
            step();
            n++;
            if (n == 2) begin
                check_eq({tag, "_busy"}, 32'(busy), 32'd1);
                addr  = 32'hFFFF_FFF0;
                wdata = 32'h0BAD_0BAD;
                we    = ~w;
            end
            if (ready) break;
        end
        check_eq({tag, "_lat"}, 32'(n), 32'(exp_lat));
        check_eq({tag, "_rdata"}, rdata, exp_rdata);
        check_eq({tag, "_err"}, 32'(err), 32'(exp_err));
        if (!hold) begin
            req = 1'b0;
            step();
            check_eq({tag, "_pulse"}, {30'd0, ready, err}, 32'd0);
            check_eq({tag, "_idle"}, 32'(busy), 32'd0);
            check_eq({tag, "_hold"}, rdata, exp_rdata);
        end
    endtask

    task automatic access0(input string tag, input logic w, input logic [31:0] a,
                           input logic [31:0] d, input logic [31:0] exp_rdata,
                           input logic exp_err);
        int n;
        int nb;
        req0   = 1'b1;
        we0    = w;
        addr0  = a;
        wdata0 = d;
        n      = 0;
        nb     = 0;
        while (n < 20) begin
            step();
            n++;
            if (busy0) nb++;
            if (ready0) break;
        end
        req0 = 1'b0;
        check_eq({tag, "_lat"}, 32'(n), 32'd1);
        check_eq({tag, "_rdata"}, rdata0, exp_rdata);
        check_eq({tag, "_err"}, 32'(err0), 32'(exp_err));
        step();
        if (busy0) nb++;
        check_eq({tag, "_busycyc"}, 32'(nb), 32'd1);
        check_eq({tag, "_pulse"}, 32'(ready0), 32'd0);
    endtask

    initial begin
        int  seen;
        reset = 1'b1;
        req   = 1'b0; we  = 1'b0; addr  = 32'h0; wdata  = 32'h0;
        req0  = 1'b0; we0 = 1'b0; addr0 = 32'h0; wdata0 = 32'h0;
        step();
        step();
        check_eq("rst_rdata", rdata, 32'h0);
        check_eq("rst_flags", {29'd0, ready, err, busy}, 32'd0);
        check_eq("rst0_rdata", rdata0, 32'h0);
        check_eq("rst0_flags", {29'd0, ready0, err0, busy0}, 32'd0);
        reset = 1'b0;

        // Basic write then read, plus the top valid word.
        access("wr10", 1'b1, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0, 3, 1'b0);
        access("rd10", 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, 3, 1'b0);
        access("rdmis", 1'b0, 32'h12, 32'h0, 32'h0, 1'b1, 3, 1'b0);
        access("wrmis", 1'b1, 32'h12, 32'h99, 32'h0, 1'b1, 3, 1'b0);
        access("rdoor", 1'b0, 32'h400, 32'h0, 32'h0, 1'b1, 3, 1'b0);
        access("wrtop", 1'b1, 32'h3FC, 32'hCAFE_F00D, 32'h0, 1'b0, 3, 1'b0);
        access("rdtop", 1'b0, 32'h3FC, 32'h0, 32'hCAFE_F00D, 1'b0, 3, 1'b0);
        access("rd10b", 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, 3, 1'b0);

        // Back-to-back with req held: the IDLE cycle adds one to the latency.
        access("b2bwr", 1'b1, 32'h0, 32'h1, 32'hDEAD_BEEF, 1'b0, 3, 1'b1);
        access("b2brd", 1'b0, 32'h0, 32'h0, 32'h1, 1'b0, 4, 1'b0);

        // Reset in the WAIT cycle of a store.
        access("wr20", 1'b1, 32'h20, 32'h1111_2222, 32'h1, 1'b0, 3, 1'b0);
        req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'hA5A5_A5A5;
        step();
        check_eq("rstw_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        req   = 1'b0;
        check_eq("rstw_rdata", rdata, 32'h0);
        check_eq("rstw_flags", {29'd0, ready, err, busy}, 32'd0);
        step();
        access("rd20", 1'b0, 32'h20, 32'h0, 32'h1111_2222, 1'b0, 3, 1'b0);

        // req withdrawn during WAIT.
        access("wr8", 1'b1, 32'h8, 32'h3333_4444, 32'h1111_2222, 1'b0, 3, 1'b0);
        req = 1'b1; we = 1'b1; addr = 32'h8; wdata = 32'h5555_5555;
        step();
        req  = 1'b0;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (ready) seen++;
        end
        check_eq("abort_ready", 32'(seen), 32'd0);
        check_eq("abort_busy", 32'(busy), 32'd0);
        access("rd8", 1'b0, 32'h8, 32'h0, 32'h3333_4444, 1'b0, 3, 1'b0);

        // Zero wait states.
        access0("l0wr4", 1'b1, 32'h4, 32'h1234_5678, 32'h0, 1'b0);
        access0("l0rd4", 1'b0, 32'h4, 32'h0, 32'h1234_5678, 1'b0);
        access0("l0oor", 1'b0, 32'h40, 32'h0, 32'h0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
